// File: rtl/instruction_fetch.sv
// PC, return stack and instruction register of the PIC16F-class core.
// Resolves sequential fetch, skip, goto/call/return and computed goto.
module instruction_fetch #(
    parameter int                  PC_WIDTH     = 13,
    parameter int                  STACK_DEPTH  = 8,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_rd_en,
    input  logic                instr_flush,
    input  logic                pc_incr_en,
    input  logic                pc_j_en,
    input  logic                pc_call_en,
    input  logic                pc_ret_en,
    input  logic                pcl_wr_en,
    input  logic [7:0]          pcl_wr_data,
    input  logic [4:0]          pclath,
    input  logic [13:0]         prog_data,
    output logic [PC_WIDTH-1:0] prog_addr,
    output logic [13:0]         instr_current,
    output logic [7:0]          pc_low,
    output logic                stack_ovf,
    output logic                stack_unf
);
    localparam int SP_W = $clog2(STACK_DEPTH);
    localparam logic [SP_W:0] CNT_FULL = (SP_W+1)'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] r_pc;
    logic [13:0]         r_instr;
    logic [SP_W-1:0]     r_sp;
    logic [SP_W:0]       r_cnt;
    logic                r_ovf;
    logic                r_unf;
    logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];

    logic                w_push;
    logic [SP_W-1:0]     w_sp_dec;
    logic [PC_WIDTH-1:0] w_jmp_tgt;
    logic [PC_WIDTH-1:0] w_pcl_tgt;
    logic [PC_WIDTH-1:0] w_pc_next;

    // A return in the same cycle as a call suppresses the push.
    assign w_push    = pc_j_en & pc_call_en & ~pc_ret_en;
    assign w_sp_dec  = r_sp - SP_W'(1);
    assign w_jmp_tgt = PC_WIDTH'({pclath[4:3], r_instr[10:0]});
    assign w_pcl_tgt = PC_WIDTH'({pclath, pcl_wr_data});

    always_comb begin
        w_pc_next = r_pc;
        if (pc_ret_en)       w_pc_next = r_stack[w_sp_dec];
        else if (pc_j_en)    w_pc_next = w_jmp_tgt;
        else if (pcl_wr_en)  w_pc_next = w_pcl_tgt;
        else if (pc_incr_en) w_pc_next = r_pc + PC_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_VECTOR;
            r_instr <= 14'h0000;
            r_sp    <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (instr_flush)      r_instr <= 14'h0000;
            else if (instr_rd_en) r_instr <= prog_data;
            // The ring keeps spinning on over/underflow; only the count saturates.
            if (pc_ret_en) begin
                r_sp <= w_sp_dec;
                if (r_cnt == '0) r_unf <= 1'b1;
                else             r_cnt <= r_cnt - (SP_W+1)'(1);
            end else if (w_push) begin
                r_sp <= r_sp + SP_W'(1);
                if (r_cnt == CNT_FULL) r_ovf <= 1'b1;
                else                   r_cnt <= r_cnt + (SP_W+1)'(1);
            end
        end
    end

    // Stack storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && w_push) r_stack[r_sp] <= r_pc;
    end

    assign prog_addr     = r_pc;
    assign instr_current = r_instr;
    assign pc_low        = r_pc[7:0];
    assign stack_ovf     = r_ovf;
    assign stack_unf     = r_unf;
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Program-counter and instruction-register unit for the PIC16F-class core: the consumer of the decoder's `instr_rd_en`, `instr_flush`, `pc_incr_en` and `pc_j_en` strobes, and the producer of `instr_current`. It owns the PC, the 8-level circular return-address stack, the program-memory address, and the one-deep fetch pipeline. Skip, `goto`, `call`, `return` and computed-`goto` (PCL write) are all resolved here.

## Interface
- PC_WIDTH, 13, program counter / program-memory address width.
- STACK_DEPTH, 8, return-stack entries; must be a power of 2.
- RESET_VECTOR, 0, PC value after reset.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- instr_rd_en  in  1  load `instr_current` from `prog_data`.
- instr_flush  in  1  load `instr_current` with NOP (14'h0000); overrides `instr_rd_en`.
- pc_incr_en  in  1  PC <= PC+1.
- pc_j_en  in  1  PC <= {pclath[4:3], instr_current[10:0]} (goto/call target).
- pc_call_en  in  1  with `pc_j_en`: push current PC before jumping.
- pc_ret_en  in  1  PC <= popped stack entry.
- pcl_wr_en  in  1  computed goto: PC <= {pclath[4:0], pcl_wr_data}.
- pcl_wr_data  in  8  new PCL value.
- pclath  in  5  PCLATH register contents.
- prog_data  in  14  program-memory word at `prog_addr`, combinational read.
- prog_addr  out  PC_WIDTH  equals PC register.
- instr_current  out  14  instruction under execution.
- pc_low  out  8  PC[7:0], PCL read value.
- stack_ovf  out  1  sticky: push performed while stack full.
- stack_unf  out  1  sticky: pop performed while stack empty.

## Operation
- PC always points to the next word to fetch; `instr_current` holds the word being executed.
- Instruction register, per cycle: `instr_flush` -> 14'h0000; else `instr_rd_en` -> `prog_data`; else hold.
- PC next-value priority: `pc_ret_en` > `pc_j_en` > `pcl_wr_en` > `pc_incr_en` > hold. Increment wraps 13'h1FFF -> 0.
- Jump target uses the `instr_current` value of the same cycle, not the value being loaded.
- Call: `pc_j_en & pc_call_en` writes the current PC (already return address) to stack[sp], sp <= sp+1. `pc_call_en` without `pc_j_en` is ignored.
- Return: PC <= stack[sp-1], sp <= sp-1.
- Stack is circular. sp is log2(STACK_DEPTH) bits plus an occupancy count 0..STACK_DEPTH.
  - Push at count=8 overwrites the oldest entry and sets `stack_ovf`; count stays 8.
  - Pop at count=0 still returns stack[sp-1] (wrapped) and sets `stack_unf`; count stays 0.
- Push and return in the same cycle: return wins, no push.
- Stack contents are not cleared by reset; only sp and count are.

## Timing
- Reset values: PC=RESET_VECTOR, `instr_current`=14'h0000, sp=0, count=0, `stack_ovf`=0, `stack_unf`=0. Hence `prog_addr`=RESET_VECTOR and `pc_low`=RESET_VECTOR[7:0].
- All updates are registered. Strobes sampled at edge N are visible after edge N; `prog_addr` follows PC with zero extra latency.
- The decoder asserts fetch strobes in Q3 only, giving:
  - Sequential instruction: 4 cycles.
  - Skip taken: flush and incr together; the skipped word is replaced by NOP, costing 4 cycles.
  - goto/call/return: flush and jump together; the NOP executes next, then the target is fetched, for 8 cycles total.
- Strobes are level-sensitive per cycle; holding one asserted for k cycles applies it k times.
- `rst` asserted mid-instruction overrides every strobe that cycle.

## Test plan
- Reset, memory all NOP, `instr_rd_en`+`pc_incr_en` pulsed every 4th cycle for 3 pulses -> PC 0->1->2->3; `instr_current`=0 throughout.
- prog[0]=14'h3055 (movlw 0x55); one rd+incr pulse -> `instr_current`=14'h3055, `prog_addr`=1.
- `instr_current`=14'h2ABC (goto), pclath=5'b11000; flush+j -> PC=13'h1ABC, `instr_current`=0.
- Skip: PC=4, prog[4]=14'h3001; flush+incr -> `instr_current`=0, PC=5.
- 9 calls from PC=0x010,0x020..0x090, then 9 returns -> `stack_ovf`=1 after the 9th call; returns yield 0x090..0x020, then 0x090 with `stack_unf`=1.
- pclath=5'h02, `pcl_wr_data`=8'h34, `pcl_wr_en` with `pc_incr_en` the same cycle -> PC=13'h0234. Then `pc_ret_en`+`pc_j_en` together -> return target wins.
